// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the match timer: bit positions inside the per-channel
// match control field and the external-match action encodings, plus a helper
// that computes the next external-match output for a given action.
// -----------------------------------------------------------------------------
package timer_pkg;

    // Bit positions inside each 3-bit per-channel match control field
    localparam int unsigned MCR_INT_EN = 0;
    localparam int unsigned MCR_RST    = 1;
    localparam int unsigned MCR_STOP   = 2;
    localparam int unsigned MCR_W      = 3;
    localparam int unsigned EMC_W      = 2;

    // External-match actions applied to em[i] on a match event
    typedef enum logic [1:0] {
        EMC_NONE   = 2'd0,
        EMC_CLEAR  = 2'd1,
        EMC_SET    = 2'd2,
        EMC_TOGGLE = 2'd3
    } emc_e;

    // Next value of an external-match output when its channel matches
    function automatic logic em_next(input logic [1:0] act, input logic cur);
        logic nxt;
        case (act)
            EMC_CLEAR:  nxt = 1'b0;
            EMC_SET:    nxt = 1'b1;
            EMC_TOGGLE: nxt = ~cur;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/timer_match_ch.sv
// -----------------------------------------------------------------------------
// timer_match_ch
// One match channel: compares the pre-increment timer value against its match
// value on each enabled tick, owns its sticky interrupt flag and external-match
// flop, and raises stop/reset requests for the counter logic in the top.
//
// Ports
//   clk, reset     clock, asynchronous active-low reset
//   match_en       counter ticked this cycle and comparisons are armed
//   tc             current (pre-increment) timer count
//   mr             match value for this channel
//   mcr            {stop, reset, int_en}
//   emc            external-match action
//   ir_clr         write-1-to-clear for ir (loses to a simultaneous set)
//   ir, em         sticky interrupt flag, external-match output (registered)
//   rst_req        match event with reset enabled (combinational)
//   stop_req       match event with stop enabled (combinational)
// -----------------------------------------------------------------------------
module timer_match_ch
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match_en,
    input  logic [WIDTH-1:0] tc,
    input  logic [WIDTH-1:0] mr,
    input  logic [2:0]       mcr,
    input  logic [1:0]       emc,
    input  logic             ir_clr,
    output logic             ir,
    output logic             em,
    output logic             rst_req,
    output logic             stop_req
);

    logic match_s;
    logic ir_r;
    logic em_r;

    assign match_s  = match_en && (tc == mr);
    assign rst_req  = match_s && mcr[MCR_RST];
    assign stop_req = match_s && mcr[MCR_STOP];
    assign ir       = ir_r;
    assign em       = em_r;

    // Sticky interrupt flag (set beats clear) and external-match output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_r <= 1'b0;
            em_r <= 1'b0;
        end else begin
            if (match_s && mcr[MCR_INT_EN]) begin
                ir_r <= 1'b1;
            end else if (ir_clr) begin
                ir_r <= 1'b0;
            end else begin
                ir_r <= ir_r;
            end
            if (match_s) begin
                em_r <= em_next(emc, em_r);
            end else begin
                em_r <= em_r;
            end
        end
    end

endmodule

// File: rtl/timer_match_n.sv
// -----------------------------------------------------------------------------
// timer_match_n
// Prescaled timer with NUM_MATCH match channels. The prescale counter pc runs
// while the run flag is set and produces a tick when it reaches the prescale
// terminal value; each tick advances the timer counter tc unless a matching
// channel requests reset (tc -> 0) or stop (tc held, run flag cleared).
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   start, stop              run-flag set / clear pulses (stop wins)
//   cnt_rst                  level; holds pc and tc at 0, suppresses matches
//   cfg_we                   loads cfg_pr/cfg_mr/cfg_mcr/cfg_emc into shadows
//   cfg_pr                   prescale terminal value
//   cfg_mr                   match values, channel i at [i*WIDTH +: WIDTH]
//   cfg_mcr                  {stop, reset, int_en} per channel at [i*3 +: 3]
//   cfg_emc                  external-match action per channel at [i*2 +: 2]
//   ir_clr                   write-1-to-clear mask for ir
//   tc, pc, running          timer count, prescale count, run flag
//   ir, irq, em              sticky flags, OR of flags, external-match outputs
// -----------------------------------------------------------------------------
module timer_match_n
    import timer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_MATCH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           cnt_rst,
    input  logic                           cfg_we,
    input  logic [WIDTH-1:0]               cfg_pr,
    input  logic [NUM_MATCH*WIDTH-1:0]     cfg_mr,
    input  logic [NUM_MATCH*MCR_W-1:0]     cfg_mcr,
    input  logic [NUM_MATCH*EMC_W-1:0]     cfg_emc,
    input  logic [NUM_MATCH-1:0]           ir_clr,
    output logic [WIDTH-1:0]               tc,
    output logic [WIDTH-1:0]               pc,
    output logic                           running,
    output logic [NUM_MATCH-1:0]           ir,
    output logic                           irq,
    output logic [NUM_MATCH-1:0]           em
);

    logic [WIDTH-1:0]           pr_r;
    logic [NUM_MATCH*WIDTH-1:0] mr_r;
    logic [NUM_MATCH*MCR_W-1:0] mcr_r;
    logic [NUM_MATCH*EMC_W-1:0] emc_r;

    logic [WIDTH-1:0]     pc_r, pc_nxt_s;
    logic [WIDTH-1:0]     tc_r, tc_nxt_s;
    logic                 running_r, running_nxt_s;
    // Set after a stop-match leaves tc parked on a match value, so the
    // first tick after a restart moves tc on instead of re-matching and
    // stopping again on the same count.
    logic                 hold_r, hold_nxt_s;

    logic                 tick_s;
    logic                 match_en_s;
    logic [NUM_MATCH-1:0] rst_req_s;
    logic [NUM_MATCH-1:0] stop_req_s;
    logic                 any_rst_s;
    logic                 any_stop_s;

    assign tick_s     = running_r && !cnt_rst && (pc_r == pr_r);
    assign match_en_s = tick_s && !hold_r;
    assign any_rst_s  = |rst_req_s;
    assign any_stop_s = |stop_req_s;

    assign tc      = tc_r;
    assign pc      = pc_r;
    assign running = running_r;
    assign irq     = |ir;

    // Configuration shadow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pr_r  <= {WIDTH{1'b0}};
            mr_r  <= {(NUM_MATCH*WIDTH){1'b0}};
            mcr_r <= {(NUM_MATCH*MCR_W){1'b0}};
            emc_r <= {(NUM_MATCH*EMC_W){1'b0}};
        end else if (cfg_we) begin
            pr_r  <= cfg_pr;
            mr_r  <= cfg_mr;
            mcr_r <= cfg_mcr;
            emc_r <= cfg_emc;
        end else begin
            pr_r  <= pr_r;
            mr_r  <= mr_r;
            mcr_r <= mcr_r;
            emc_r <= emc_r;
        end
    end

    // Next-state for counters, run flag and stop-hold marker
    always_comb begin
        pc_nxt_s      = pc_r;
        tc_nxt_s      = tc_r;
        running_nxt_s = running_r;
        hold_nxt_s    = hold_r;

        if (cnt_rst) begin
            pc_nxt_s   = {WIDTH{1'b0}};
            tc_nxt_s   = {WIDTH{1'b0}};
            hold_nxt_s = 1'b0;
        end else if (tick_s) begin
            pc_nxt_s   = {WIDTH{1'b0}};
            hold_nxt_s = any_stop_s && !any_rst_s;
            if (any_rst_s) begin
                tc_nxt_s = {WIDTH{1'b0}};
            end else if (any_stop_s) begin
                tc_nxt_s = tc_r;
            end else begin
                tc_nxt_s = tc_r + WIDTH'(1'b1);
            end
        end else if (running_r) begin
            pc_nxt_s = pc_r + WIDTH'(1'b1);
        end else begin
            pc_nxt_s = pc_r;
        end

        if (stop || any_stop_s) begin
            running_nxt_s = 1'b0;
        end else if (start) begin
            running_nxt_s = 1'b1;
        end else begin
            running_nxt_s = running_r;
        end
    end

    // Counter and run-flag state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r      <= {WIDTH{1'b0}};
            tc_r      <= {WIDTH{1'b0}};
            running_r <= 1'b0;
            hold_r    <= 1'b0;
        end else begin
            pc_r      <= pc_nxt_s;
            tc_r      <= tc_nxt_s;
            running_r <= running_nxt_s;
            hold_r    <= hold_nxt_s;
        end
    end

    for (genvar i = 0; i < NUM_MATCH; i++) begin : g_ch
        timer_match_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .match_en (match_en_s),
            .tc       (tc_r),
            .mr       (mr_r[i*WIDTH +: WIDTH]),
            .mcr      (mcr_r[i*MCR_W +: MCR_W]),
            .emc      (emc_r[i*EMC_W +: EMC_W]),
            .ir_clr   (ir_clr[i]),
            .ir       (ir[i]),
            .em       (em[i]),
            .rst_req  (rst_req_s[i]),
            .stop_req (stop_req_s[i])
        );
    end

endmodule

// File: tb/tb_timer_match_n.sv
// -----------------------------------------------------------------------------
// tb_timer_match_n
// Directed bench for timer_match_n (WIDTH=8, NUM_MATCH=4). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_timer_match_n;

    localparam int W  = 8;
    localparam int NM = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, stop, cnt_rst, cfg_we;
    logic [W-1:0]    cfg_pr;
    logic [NM*W-1:0] cfg_mr;
    logic [NM*3-1:0] cfg_mcr;
    logic [NM*2-1:0] cfg_emc;
    logic [NM-1:0]   ir_clr;
    logic [W-1:0]    tc, pc;
    logic            running, irq;
    logic [NM-1:0]   ir, em;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    timer_match_n #(.WIDTH(W), .NUM_MATCH(NM)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .cnt_rst (cnt_rst),
        .cfg_we  (cfg_we),
        .cfg_pr  (cfg_pr),
        .cfg_mr  (cfg_mr),
        .cfg_mcr (cfg_mcr),
        .cfg_emc (cfg_emc),
        .ir_clr  (ir_clr),
        .tc      (tc),
        .pc      (pc),
        .running (running),
        .ir      (ir),
        .irq     (irq),
        .em      (em)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [W-1:0] pr, input logic [NM*W-1:0] mr,
                            input logic [NM*3-1:0] mcr, input logic [NM*2-1:0] emc);
        cfg_pr  = pr;
        cfg_mr  = mr;
        cfg_mcr = mcr;
        cfg_emc = emc;
        cfg_we  = 1'b1;
        step(1);
        cfg_we  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic pulse_cnt_rst();
        cnt_rst = 1'b1;
        step(1);
        cnt_rst = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; cnt_rst = 1'b0; cfg_we = 1'b0;
        cfg_pr = '0; cfg_mr = '0; cfg_mcr = '0; cfg_emc = '0; ir_clr = '0;

        // Reset state
        step(2);
        check("rst_tc", tc, 0);
        check("rst_pc", pc, 0);
        check("rst_running", running, 0);
        check("rst_ir", ir, 0);
        check("rst_em", em, 0);
        check("rst_irq", irq, 0);
        reset = 1'b1;
        step(3);
        check("idle_no_start_pc", pc, 0);

        // pr=2, ch0 mr=3 int_en|reset: each tc value lasts 3 cycles
        load_cfg(8'd2, 32'h0000_0003, 12'h003, 8'h00);
        pulse_start();
        check("p2_run", running, 1);
        step(2);
        check("p2_pc2", pc, 2);
        check("p2_tc0", tc, 0);
        step(1);
        check("p2_tc1", tc, 1);
        check("p2_pc_wrap", pc, 0);
        step(6);
        check("p2_tc3", tc, 3);
        check("p2_ir_pre", ir, 0);
        step(3);
        check("p2_tc_rst", tc, 0);
        check("p2_ir", ir, 4'b0001);
        check("p2_irq", irq, 1);
        check("p2_pc0", pc, 0);

        // ir clear, then clear coinciding with a new set
        ir_clr = 4'b0001;
        step(1);
        check("irclr_0", ir, 0);
        check("irclr_irq", irq, 0);
        ir_clr = 4'b0000;
        step(10);
        check("irclr_tc3", tc, 3);
        ir_clr = 4'b0001;
        step(1);
        check("irclr_set_wins", ir, 4'b0001);
        check("irclr_set_tc", tc, 0);
        step(1);
        check("irclr_next", ir, 0);
        ir_clr = 4'b0000;

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check("startstop_run", running, 0);
        check("startstop_pc", pc, 2);
        step(2);
        check("stopped_pc_hold", pc, 2);
        pulse_cnt_rst();
        check("cntrst_pc", pc, 0);

        // pr=0, ch1 mr=5 stop: stops on 5, restart resumes to 6
        load_cfg(8'd0, 32'h0000_0500, 12'h020, 8'h00);
        pulse_start();
        check("mstop_tc0", tc, 0);
        step(5);
        check("mstop_tc5_run", running, 1);
        step(1);
        check("mstop_tc", tc, 5);
        check("mstop_run", running, 0);
        check("mstop_pc", pc, 0);
        step(2);
        check("mstop_hold", tc, 5);
        pulse_start();
        check("mstop_restart_run", running, 1);
        step(1);
        check("mstop_resume", tc, 6);
        check("mstop_ir", ir, 0);
        pulse_stop();
        pulse_cnt_rst();

        // ch2 mr=2 reset toggle, ch3 mr=2 int_en set: both match together
        load_cfg(8'd0, 32'h0202_0000, 12'h280, 8'hB0);
        pulse_start();
        step(2);
        check("tog_tc2", tc, 2);
        check("tog_em_pre", em, 0);
        step(1);
        check("tog_tc_rst", tc, 0);
        check("tog_em1", em, 4'b1100);
        check("tog_ir", ir, 4'b1000);
        step(3);
        check("tog_em2", em, 4'b1000);
        step(3);
        check("tog_em3", em, 4'b1100);
        pulse_stop();
        pulse_cnt_rst();

        // 8-bit wrap with no flags
        ir_clr = 4'b1111;
        step(1);
        ir_clr = 4'b0000;
        check("wrap_ir_clr", ir, 0);
        load_cfg(8'd0, 32'h0000_0000, 12'h000, 8'h00);
        pulse_start();
        check("wrap_tc0", tc, 0);
        step(255);
        check("wrap_tc255", tc, 255);
        step(1);
        check("wrap_tc_zero", tc, 0);
        check("wrap_ir", ir, 0);
        check("wrap_run", running, 1);

        // cnt_rst held mid-count, then asynchronous reset mid-count
        step(10);
        check("mid_tc10", tc, 10);
        cnt_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("cr_tc", tc, 0);
            check("cr_pc", pc, 0);
            check("cr_run", running, 1);
            check("cr_em", em, 4'b1100);
        end
        cnt_rst = 1'b0;
        step(3);
        check("cr_resume", tc, 3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_tc", tc, 0);
        check("arst_pc", pc, 0);
        check("arst_run", running, 0);
        check("arst_em", em, 0);
        check("arst_irq", irq, 0);
        reset = 1'b1;
        step(3);
        check("post_rst_idle_tc", tc, 0);
        check("post_rst_idle_run", running, 0);
        pulse_start();
        step(1);
        check("post_rst_pr0_tc", tc, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
